keypad_calc_engine: RTL

- Parametrised successor of the two-operand keypad adder.
- Collects two decimal operands from the keypad scan-code stream as BCD digits, one per press.
- Accepts one of three operators: add, subtract, multiply.
- On "=", converts both operands to binary over several cycles and computes a signed-magnitude result; multiply uses a shift-add unit.
- Sits between the keypad scanner (press/scan_code) and the 7-segment display/result formatter.

---
 rtl/keypad_calc_engine.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_calc_engine.sv
`default_nettype none
// ============================================================================
// keypad_calc_engine : two-operand BCD keypad calculator (add / sub / mul).
// Optional backspace key enabled by `define KEYPAD_BACKSPACE_EN.
// Revision: 1.0
// ============================================================================
module keypad_calc_engine #(
  parameter int DIGITS = 6,
  parameter int OPW    = 20,
  parameter int RESW   = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  press,
  input  logic [3:0]            scan_code,
  output logic [RESW-1:0]       result,
  output logic                  result_neg,
  output logic                  result_valid,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   disp_bcd,
  output logic [DIGITS-1:0]     disp_flag,
  output logic [1:0]            op_code
);

  localparam int C_CMAX = (OPW > DIGITS) ? OPW : DIGITS;
  localparam int C_CW   = $clog2(C_CMAX + 1);

  typedef enum logic [2:0] {
    S_ENTER_A = 3'd0,
    S_ENTER_B = 3'd1,
    S_CONV    = 3'd2,
    S_EXEC    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [4*DIGITS-1:0]  r_buf_a, r_buf_b;
  logic [DIGITS-1:0]    r_flag_a, r_flag_b;
  logic [1:0]           r_op;
  logic [RESW-1:0]      r_acc_a;
  logic [OPW-1:0]       r_acc_b;
  logic [RESW-1:0]      r_prod;
  logic [C_CW-1:0]      r_cnt;
  logic [RESW-1:0]      r_result;
  logic                 r_neg;
  logic                 r_valid;

  logic                 w_digit, w_opkey, w_eq, w_clr;
  logic [1:0]           w_op_sel;
  logic                 w_conv_last, w_exec_last;
  logic [C_CW-1:0]      w_pos;
  logic [3:0]           w_dig_a, w_dig_b;
  logic [RESW-1:0]      w_b_ext;

  assign w_digit  = press && (scan_code <= 4'd9);
  assign w_opkey  = press && (scan_code inside {4'ha, 4'hb, 4'hc});
  assign w_eq     = press && (scan_code == 4'hd);
  assign w_clr    = press && (scan_code == 4'he);
  assign w_op_sel = (scan_code == 4'ha) ? 2'b01 : (scan_code == 4'hb) ? 2'b10 : 2'b00;
`ifdef KEYPAD_BACKSPACE_EN
  logic w_bs;
  assign w_bs = press && (scan_code == 4'hf);
`endif

  assign w_conv_last = (r_cnt == C_CW'(DIGITS - 1));
  assign w_exec_last = (r_op == 2'b10) ? (r_cnt == C_CW'(OPW - 1)) : 1'b1;
  assign w_pos       = C_CW'(DIGITS - 1) - r_cnt;
  assign w_b_ext     = RESW'(r_acc_b);

  // Digit at the current conversion position, MSB first; empty slots give 0.
  always_comb begin
    w_dig_a = 4'd0;
    w_dig_b = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_pos == C_CW'(i)) begin
        if (r_flag_a[i]) w_dig_a = r_buf_a[4*i +: 4];
        if (r_flag_b[i]) w_dig_b = r_buf_b[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_ENTER_A;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    disp_bcd    = r_buf_b;
    disp_flag   = r_flag_b;
    if (w_clr) begin
      w_state_nxt = S_ENTER_A;
    end else begin
      case (r_state)
        S_ENTER_A: if (w_opkey) w_state_nxt = S_ENTER_B;
                   else if (w_eq) w_state_nxt = S_CONV;
        S_ENTER_B: if (w_eq) w_state_nxt = S_CONV;
        S_CONV:    if (w_conv_last) w_state_nxt = S_EXEC;
        S_EXEC:    if (w_exec_last) w_state_nxt = S_DONE;
        S_DONE:    if (w_digit) w_state_nxt = S_ENTER_A;
        default:   w_state_nxt = S_ENTER_A;
      endcase
    end
    case (r_state)
      S_ENTER_A: begin
        disp_bcd  = r_buf_a;
        disp_flag = r_flag_a;
      end
      S_CONV, S_EXEC: busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || w_clr) begin
      r_buf_a  <= '0;
      r_buf_b  <= '0;
      r_flag_a <= '0;
      r_flag_b <= '0;
      r_op     <= 2'b00;
      r_acc_a  <= '0;
      r_acc_b  <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_neg    <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_ENTER_A: begin
          if (w_digit) begin
            if (!r_flag_a[DIGITS-1]) begin
              r_buf_a  <= {r_buf_a[4*DIGITS-5:0], scan_code};
              r_flag_a <= {r_flag_a[DIGITS-2:0], 1'b1};
            end
          end else if (w_opkey) begin
            r_op <= w_op_sel;
          end else if (w_eq) begin
            r_op    <= 2'b00;
            r_acc_a <= '0;
            r_acc_b <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
          end
`ifdef KEYPAD_BACKSPACE_EN
          else if (w_bs) begin
            r_buf_a  <= r_buf_a >> 4;
            r_flag_a <= r_flag_a >> 1;
          end
`endif
        end
        S_ENTER_B: begin
          if (w_digit) begin
            if (!r_flag_b[DIGITS-1]) begin
              r_buf_b  <= {r_buf_b[4*DIGITS-5:0], scan_code};
              r_flag_b <= {r_flag_b[DIGITS-2:0], 1'b1};
            end
          end else if (w_opkey) begin
            if (r_flag_b == '0) r_op <= w_op_sel;
          end else if (w_eq) begin
            r_acc_a <= '0;
            r_acc_b <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
          end
`ifdef KEYPAD_BACKSPACE_EN
          else if (w_bs) begin
            r_buf_b  <= r_buf_b >> 4;
            r_flag_b <= r_flag_b >> 1;
          end
`endif
        end
        S_CONV: begin
          r_acc_a <= (r_acc_a << 3) + (r_acc_a << 1) + RESW'(w_dig_a);
          r_acc_b <= (r_acc_b << 3) + (r_acc_b << 1) + OPW'(w_dig_b);
          r_cnt   <= w_conv_last ? '0 : r_cnt + 1'b1;
        end
        S_EXEC: begin
          if (w_exec_last) begin
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_neg   <= 1'b0;
            case (r_op)
              2'b01: begin
                if (r_acc_a >= w_b_ext) begin
                  r_result <= r_acc_a - w_b_ext;
                end else begin
                  r_result <= w_b_ext - r_acc_a;
                  r_neg    <= 1'b1;
                end
              end
              2'b10:   r_result <= r_prod + (r_acc_b[0] ? r_acc_a : '0);
              default: r_result <= r_acc_a + w_b_ext;
            endcase
          end else begin
            // Shift-add: acc_a doubles as the shifted multiplicand, acc_b as the multiplier.
            if (r_acc_b[0]) r_prod <= r_prod + r_acc_a;
            r_acc_a <= r_acc_a << 1;
            r_acc_b <= r_acc_b >> 1;
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (w_digit) begin
            r_buf_a  <= (4*DIGITS)'(scan_code);
            r_flag_a <= DIGITS'(1);
            r_buf_b  <= '0;
            r_flag_b <= '0;
            r_op     <= 2'b00;
          end
        end
        default: ;
      endcase
    end
  end

  assign result       = r_result;
  assign result_neg   = r_neg;
  assign result_valid = r_valid;
  assign op_code      = r_op;

endmodule
`default_nettype wire
